threshold_read: RTL and testbench
=================================

# threshold_read

Upstream pixel source for the BMP writer stage. It fetches pixel pairs, two pixels per word, from a synchronous-read image memory in raster order. Each pixel is binarised against a fixed threshold. Results are emitted as even/odd RGB byte pairs qualified by `horizontal_Pulse`, with programmable vertical and horizontal blanking. One `start` pulse produces exactly one frame of `IMAGE_WIDTH/2 * IMAGE_HEIGHT` output pairs, followed by a done pulse.

## Interface

**Parameters**
- `IMAGE_WIDTH`, 768: pixels per row; must be even.
- `IMAGE_HEIGHT`, 512: rows per frame.
- `THRESHOLD`, 90: 8-bit binarisation level.
- `START_DELAY`, 100: blank cycles between `start` and the first read. Must be at least 1.
- `HSYNC_DELAY`, 160: blank cycles between rows. Must be at least 1.
- `ADDR_WIDTH`, 18: pair-address width; `2^ADDR_WIDTH` must be at least `IMAGE_WIDTH/2 * IMAGE_HEIGHT`.

**Ports**
- One clock; reset is synchronous and active-high.
- `clk`, input, 1: clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: single-cycle frame request.
- `mem_Rd_En`, output, 1: memory read strobe.
- `mem_Rd_Addr`, output, `ADDR_WIDTH`: pair address, equal to `row*(IMAGE_WIDTH/2)+pair`.
- `mem_Rd_Data`, input, 48: `{R_even, G_even, B_even, R_odd, G_odd, B_odd}`. Valid the cycle after `mem_Rd_En`.
- `horizontal_Pulse`, output, 1: output pair valid.
- `data_Red_Even`, `data_Green_Even`, `data_Blue_Even`, output, 8 each: binarised even pixel.
- `data_Red_Odd`, `data_Green_Odd`, `data_Blue_Odd`, output, 8 each: binarised odd pixel.
- `busy`, output, 1: frame in progress.
- `sig_Threshold_Done`, output, 1: one-cycle end-of-frame pulse.

## Operation

**Reset values.** All outputs reset to 0, state resets to IDLE and all counters reset to 0.

**States.**
- IDLE
  - `start`=1 → VSYNC, with the delay counter cleared.
  - `start` is ignored in every other state.
- VSYNC: held for exactly `START_DELAY` cycles, then → DATA.
- DATA
  - Held for exactly `IMAGE_WIDTH/2` cycles.
  - `mem_Rd_En`=1 on every DATA cycle; `mem_Rd_Addr` increments by 1 per cycle, starting at 0 for the frame.
  - At the end of a row:
    - not the last row → HSYNC;
    - last row → DRAIN.
- HSYNC: held for exactly `HSYNC_DELAY` cycles with `mem_Rd_En`=0, then → DATA for the next row.
- DRAIN: waits for the pipeline to empty, pulses `sig_Threshold_Done`, then → IDLE.

**Row order.** Rows are read top-to-bottom, address 0 first. Vertical flipping is the writer's job.

**Binarise rule.** Applied per pixel:
- `sum = R+G+B`, computed at 10 bits with no overflow; the maximum is 765.
- If `sum > 3*THRESHOLD` (10-bit compare), all three output channels = 255; otherwise all = 0.
- Equality maps to 0.

**Output data.** Data outputs hold their last value while `horizontal_Pulse`=0.

**`busy`.** High from the cycle after `start` is accepted through the `sig_Threshold_Done` cycle, inclusive.

**Reset mid-frame.** Returns to IDLE immediately. No further `horizontal_Pulse` and no done pulse are produced. The next `start` begins again at address 0.

## Timing

- Read pipeline: memory captures the address at the end of cycle T, returns data during T+1, and the block registers the binarised result at the end of T+1.
- `horizontal_Pulse` is high in cycle T+2 for a `mem_Rd_En` in cycle T. Fixed latency is 2, with one pulse per read and no gaps within a row.
- `start` sampled at the edge ending cycle 0 → first `mem_Rd_En` in cycle `START_DELAY+1`.
- Gap between the last read of row r and the first read of row r+1 is exactly `HSYNC_DELAY` cycles.
- `sig_Threshold_Done` is high in the cycle after the final `horizontal_Pulse`.
- `start` asserted together with `sig_Threshold_Done` is ignored. `start` asserted in the following IDLE cycle is accepted.
- A frame occupies `START_DELAY + H*(W/2) + (H-1)*HSYNC_DELAY + 3` cycles from acceptance to done, inclusive.

## Test plan

1. **Frame timing.** Params W=4, H=2, START_DELAY=2, HSYNC_DELAY=3; `start` in cycle 0. Required response:
   - `mem_Rd_En` high in cycles 3-4 (addresses 0,1) and 8-9 (addresses 2,3);
   - `horizontal_Pulse` high in cycles 5, 6, 10, 11;
   - done high in cycle 12;
   - `busy` high in cycles 1-12.
2. **Threshold boundary.** THRESHOLD=90:
   - even pixel (90,90,90) → 0,0,0;
   - odd pixel (91,90,90) → 255,255,255;
   - (255,255,255) → 255 with no overflow;
   - (0,0,0) → 0.
3. **Start while busy.** `start` re-pulsed during VSYNC, DATA and HSYNC → no restart; exactly 4 pulses and 1 done.
4. **Reset mid-frame.** Reset in cycle 8 → all outputs 0 from cycle 9 and no done pulse. A new `start` → reads begin at address 0 with full frame timing.
5. **Back-to-back frames.** `start` coincident with done → ignored. `start` the cycle after done → second frame identical to the first.
6. **Full-size frame.** Default params against a BMP writer model. Required response:
   - 196608 pulses;
   - last `mem_Rd_Addr` = 196607;
   - 2-cycle latency holds on every pulse;
   - frame length matches the formula in Timing.

Source files
------------

// File: rtl/threshold_read_if.sv
// Memory-read and binarised-pixel signals between threshold_read (master)
// and the image memory / BMP writer side (slave).
interface threshold_read_if #(
  parameter int unsigned ADDR_WIDTH = 18
) ();
  logic                  mem_Rd_En;
  logic [ADDR_WIDTH-1:0] mem_Rd_Addr;
  logic [47:0]           mem_Rd_Data;
  logic                  horizontal_Pulse;
  logic [7:0]            data_Red_Even;
  logic [7:0]            data_Green_Even;
  logic [7:0]            data_Blue_Even;
  logic [7:0]            data_Red_Odd;
  logic [7:0]            data_Green_Odd;
  logic [7:0]            data_Blue_Odd;

  modport master (
    output mem_Rd_En,
    output mem_Rd_Addr,
    input  mem_Rd_Data,
    output horizontal_Pulse,
    output data_Red_Even,
    output data_Green_Even,
    output data_Blue_Even,
    output data_Red_Odd,
    output data_Green_Odd,
    output data_Blue_Odd
  );

  modport slave (
    input  mem_Rd_En,
    input  mem_Rd_Addr,
    output mem_Rd_Data,
    input  horizontal_Pulse,
    input  data_Red_Even,
    input  data_Green_Even,
    input  data_Blue_Even,
    input  data_Red_Odd,
    input  data_Green_Odd,
    input  data_Blue_Odd
  );
endinterface

// File: rtl/threshold_read.sv
// Raster-order pixel-pair reader: fetches two pixels per word, binarises each
// against a fixed threshold and emits them with vertical/horizontal blanking.
module threshold_read #(
  parameter int unsigned IMAGE_WIDTH  = 768,
  parameter int unsigned IMAGE_HEIGHT = 512,
  parameter int unsigned THRESHOLD    = 90,
  parameter int unsigned START_DELAY  = 100,
  parameter int unsigned HSYNC_DELAY  = 160,
  parameter int unsigned ADDR_WIDTH   = 18
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  threshold_read_if.master    bus,
  output logic                busy,
  output logic                sig_Threshold_Done
);

  localparam int unsigned Pairs  = IMAGE_WIDTH / 2;
  localparam int unsigned CntMax0 = (START_DELAY > HSYNC_DELAY) ? START_DELAY : HSYNC_DELAY;
  localparam int unsigned CntMax1 = (CntMax0 > Pairs) ? CntMax0 : Pairs;
  localparam int unsigned CntMax  = (CntMax1 > 3) ? CntMax1 : 3;
  localparam int unsigned CntW    = $clog2(CntMax + 1);
  localparam int unsigned RowW    = $clog2(IMAGE_HEIGHT + 1);
  localparam logic [9:0]  ThreshSum = 10'(3 * THRESHOLD);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StVsync = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StHsync = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [RowW-1:0]       row_q, row_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_en_d1_q;
  logic                  pulse_q;
  logic [47:0]           pix_q;

  function automatic logic [7:0] binarise(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b);
    logic [9:0] sum;
    sum = {2'b00, r} + {2'b00, g} + {2'b00, b};
    return (sum > ThreshSum) ? 8'hff : 8'h00;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    addr_d  = addr_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StVsync;
          cnt_d   = '0;
          row_d   = '0;
          addr_d  = '0;
        end
      end
      StVsync: begin
        if (cnt_q == CntW'(START_DELAY - 1)) begin
          state_d = StData;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        addr_d = addr_q + 1'b1;
        if (cnt_q == CntW'(Pairs - 1)) begin
          cnt_d = '0;
          if (row_q == RowW'(IMAGE_HEIGHT - 1)) begin
            state_d = StDrain;
          end else begin
            state_d = StHsync;
            row_d   = row_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHsync: begin
        if (cnt_q == CntW'(HSYNC_DELAY - 1)) begin
          state_d = StData;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        // Two cycles flush the read pipeline; the third carries the done pulse.
        if (cnt_q == CntW'(2)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      rd_en_d1_q <= 1'b0;
      pulse_q    <= 1'b0;
      pix_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      addr_q     <= addr_d;
      rd_en_d1_q <= (state_q == StData);
      pulse_q    <= rd_en_d1_q;
      if (rd_en_d1_q) begin
        pix_q <= {{3{binarise(bus.mem_Rd_Data[47:40], bus.mem_Rd_Data[39:32],
                              bus.mem_Rd_Data[31:24])}},
                  {3{binarise(bus.mem_Rd_Data[23:16], bus.mem_Rd_Data[15:8],
                              bus.mem_Rd_Data[7:0])}}};
      end
    end
  end

  always_comb begin
    bus.mem_Rd_En        = (state_q == StData);
    bus.mem_Rd_Addr      = addr_q;
    bus.horizontal_Pulse = pulse_q;
    bus.data_Red_Even    = pix_q[47:40];
    bus.data_Green_Even  = pix_q[39:32];
    bus.data_Blue_Even   = pix_q[31:24];
    bus.data_Red_Odd     = pix_q[23:16];
    bus.data_Green_Odd   = pix_q[15:8];
    bus.data_Blue_Odd    = pix_q[7:0];
    busy                 = (state_q != StIdle);
    sig_Threshold_Done   = (state_q == StDrain) && (cnt_q == CntW'(2));
  end

endmodule

// File: tb/tb_threshold_read.sv
// Self-checking bench for threshold_read: random image contents, timing and
// pixel values predicted from frame arithmetic and the binarise rule.
module tb_threshold_read;

  localparam int unsigned W     = 4;
  localparam int unsigned H     = 2;
  localparam int unsigned SD    = 2;
  localparam int unsigned HS    = 3;
  localparam int unsigned THR   = 90;
  localparam int unsigned AW    = 3;
  localparam int          NPAIR = W / 2 * H;
  localparam int          D     = SD + H * (W / 2) + (H - 1) * HS + 3;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;

  threshold_read_if #(.ADDR_WIDTH(AW)) bus ();

  threshold_read #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .THRESHOLD   (THR),
    .START_DELAY (SD),
    .HSYNC_DELAY (HS),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .bus               (bus),
    .busy              (busy),
    .sig_Threshold_Done(done)
  );

  always #5 clk = ~clk;

  logic [47:0] mem [NPAIR];
  logic [47:0] exp_data;
  logic [47:0] out_data;
  int n_checks = 0;
  int n_errors = 0;

  // Synchronous-read image memory
  always @(posedge clk) begin
    if (bus.mem_Rd_En && (int'(bus.mem_Rd_Addr) < NPAIR)) bus.mem_Rd_Data <= mem[bus.mem_Rd_Addr];
  end

  assign out_data = {bus.data_Red_Even, bus.data_Green_Even, bus.data_Blue_Even,
                     bus.data_Red_Odd, bus.data_Green_Odd, bus.data_Blue_Odd};

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] bin_pix(input int r, input int g, input int b);
    return (r + g + b > 3 * THR) ? 8'd255 : 8'd0;
  endfunction

  function automatic logic [47:0] pair_bin(input logic [47:0] w);
    logic [7:0] e, o;
    e = bin_pix(int'(w[47:40]), int'(w[39:32]), int'(w[31:24]));
    o = bin_pix(int'(w[23:16]), int'(w[15:8]), int'(w[7:0]));
    return {e, e, e, o, o, o};
  endfunction

  // Pair address read in cycle k after acceptance, or -1 if none.
  function automatic int read_addr_at(input int k);
    for (int r = 0; r < int'(H); r++) begin
      int f;
      f = SD + 1 + r * (W / 2 + HS);
      if (k >= f && k < f + int'(W / 2)) return r * (W / 2) + (k - f);
    end
    return -1;
  endfunction

  function automatic logic [23:0] rand_pix();
    if ($urandom_range(0, 1) == 1)
      return {8'($urandom_range(85, 95)), 8'($urandom_range(85, 95)), 8'($urandom_range(85, 95))};
    return 24'($urandom);
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < NPAIR; i++) mem[i] = {rand_pix(), rand_pix()};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_rd_en", 48'(bus.mem_Rd_En), 48'(0));
      check("idle_pulse", 48'(bus.horizontal_Pulse), 48'(0));
      check("idle_busy", 48'(busy), 48'(0));
      check("idle_done", 48'(done), 48'(0));
      check("idle_data_hold", out_data, exp_data);
      @(posedge clk); #1;
    end
  endtask

  // Called just after a rising edge; that cycle is cycle 0 of the frame.
  task automatic run_frame(input bit noise, input bit start_at_done, input int abort_k);
    start = 1'b1;
    @(negedge clk);
    check("k0_busy", 48'(busy), 48'(0));
    check("k0_rd_en", 48'(bus.mem_Rd_En), 48'(0));
    check("k0_pulse", 48'(bus.horizontal_Pulse), 48'(0));
    for (int k = 1; k <= D; k++) begin
      bit dead, poke;
      int ra, pa;
      @(posedge clk); #1;
      poke  = noise && (k == 1 || k == SD + 1 || k == SD + W / 2 + 1);
      start = (poke && (abort_k == 0 || k <= abort_k)) || (start_at_done && abort_k == 0 && k == D);
      reset = (k == abort_k);
      @(negedge clk);
      dead = (abort_k != 0) && (k > abort_k);
      ra   = dead ? -1 : read_addr_at(k);
      pa   = dead ? -1 : read_addr_at(k - 2);
      if (dead) exp_data = '0;
      else if (pa >= 0) exp_data = pair_bin(mem[pa]);
      check($sformatf("rd_en k=%0d", k), 48'(bus.mem_Rd_En), 48'(ra >= 0));
      if (ra >= 0 || dead)
        check($sformatf("rd_addr k=%0d", k), 48'(bus.mem_Rd_Addr), dead ? 48'(0) : 48'(ra));
      check($sformatf("pulse k=%0d", k), 48'(bus.horizontal_Pulse), 48'(pa >= 0));
      check($sformatf("data k=%0d", k), out_data, exp_data);
      check($sformatf("busy k=%0d", k), 48'(busy), 48'(!dead && k <= D));
      check($sformatf("done k=%0d", k), 48'(done), 48'(!dead && k == D));
    end
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    exp_data = '0;
    bus.mem_Rd_Data = '0;
    for (int i = 0; i < NPAIR; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_addr", 48'(bus.mem_Rd_Addr), 48'(0));
    check("rst_data", out_data, 48'(0));
    @(posedge clk); #1;
    idle(2);

    // Threshold boundary pixels in the first two pairs
    fill_mem();
    mem[0] = {8'd90, 8'd90, 8'd90, 8'd91, 8'd90, 8'd90};
    mem[1] = {8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0};
    run_frame(1'b0, 1'b0, 0);
    idle(3);

    // Start re-pulsed during VSYNC, DATA and HSYNC
    fill_mem();
    run_frame(1'b1, 1'b0, 0);
    idle(2);

    // Reset at cycle 8, then a clean frame from address 0
    fill_mem();
    run_frame(1'b0, 1'b0, 8);
    idle(2);
    fill_mem();
    run_frame(1'b0, 1'b0, 0);
    idle(1);

    // Start with done ignored, next-cycle start accepted, same image
    fill_mem();
    run_frame(1'b0, 1'b1, 0);
    run_frame(1'b0, 1'b0, 0);
    idle(2);

    for (int it = 0; it < 6; it++) begin
      bit nz, b2b;
      int ab;
      nz  = 1'($urandom_range(0, 1));
      b2b = 1'($urandom_range(0, 1));
      ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, D - 1)) : 0;
      fill_mem();
      run_frame(nz, b2b, ab);
      if (!(b2b && ab == 0)) idle(1);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
